// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared widths, register constants and forwarding-select enum (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    EX   = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    GPR  = 3'd4
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/operand_fwd_mux.sv
// ---------------------------------------------------------------------------
// operand_fwd_mux: resolves one source operand from EX/MEM/WB bypass or GPR (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module operand_fwd_mux
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [4:0]      src,
  input  logic            ex_en,
  input  logic [4:0]      ex_rw,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_en,
  input  logic [4:0]      mem_rw,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rw,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] gpr_data,
  output fwd_sel_e        sel,
  output logic [XLEN-1:0] data
);

  // Youngest producer wins; r0 is hard-wired so its writers are never forwarded.
  always_comb begin
    sel = GPR;
    if (src == REG_ZERO)                   sel = ZERO;
    else if (ex_en  && (ex_rw  == src))    sel = EX;
    else if (mem_en && (mem_rw == src))    sel = MEM;
    else if (wb_en  && (wb_rw  == src))    sel = WB;
  end

  always_comb begin
    data = '0;
    case (sel)
      ZERO:    data = '0;
      EX:      data = ex_data;
      MEM:     data = mem_data;
      WB:      data = wb_data;
      GPR:     data = gpr_data;
      default: data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage: operand forwarding, load-use detect, ID/EX register (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int XLEN   = cpu_pkg::XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_rw,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   gpr_rd1,
  input  logic [XLEN-1:0]   gpr_rd2,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic              mem_regWrite,
  input  logic [4:0]        mem_rw,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_rw,
  input  logic [XLEN-1:0]   wb_Wd,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rw,
  output logic [CTRL_W-1:0] ex_ctrl
);

  // A load in EX has no data yet, so only ALU results are bypassed from EX.
  logic            ex_fwd_en;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;
  fwd_sel_e        sel_a_unused;
  fwd_sel_e        sel_b_unused;

  assign ex_fwd_en = ex_valid && ex_regWrite && !ex_memRead;

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs (
    .src      (id_rs),
    .ex_en    (ex_fwd_en),
    .ex_rw    (ex_rw),
    .ex_data  (ex_fwd_data),
    .mem_en   (mem_regWrite),
    .mem_rw   (mem_rw),
    .mem_data (mem_data),
    .wb_en    (wb_regWrite),
    .wb_rw    (wb_rw),
    .wb_data  (wb_Wd),
    .gpr_data (gpr_rd1),
    .sel      (sel_a_unused),
    .data     (opnd_a)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rt (
    .src      (id_rt),
    .ex_en    (ex_fwd_en),
    .ex_rw    (ex_rw),
    .ex_data  (ex_fwd_data),
    .mem_en   (mem_regWrite),
    .mem_rw   (mem_rw),
    .mem_data (mem_data),
    .wb_en    (wb_regWrite),
    .wb_rw    (wb_rw),
    .wb_data  (wb_Wd),
    .gpr_data (gpr_rd2),
    .sel      (sel_b_unused),
    .data     (opnd_b)
  );

  always_comb begin
    hazard_stall = id_valid && ex_valid && ex_memRead && (ex_rw != REG_ZERO) &&
                   ((id_use_rs && (ex_rw == id_rs)) || (id_use_rt && (ex_rw == id_rt)));
  end

  // Bubbles clear only the control fields; stale data is harmless once valid drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rw       <= '0;
    end else if (flush || (!stall && hazard_stall)) begin
      ex_valid    <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_ctrl     <= '0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_regWrite <= id_valid && id_regWrite;
      ex_memRead  <= id_valid && id_memRead;
      ex_ctrl     <= id_ctrl;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_a        <= opnd_a;
      ex_b        <= opnd_b;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rw       <= id_rw;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage: directed bench with behavioural pipeline/regfile model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall, flush, id_valid, id_use_rs, id_use_rt, id_regWrite, id_memRead;
  logic [31:0] id_pc, id_imm, gpr_rd1, gpr_rd2, ex_fwd_data, mem_data, wb_Wd;
  logic [4:0]  id_rs, id_rt, id_rw, mem_rw, wb_rw;
  logic [15:0] id_ctrl;
  logic        mem_regWrite, wb_regWrite;
  logic        hazard_stall, ex_valid, ex_regWrite, ex_memRead;
  logic [31:0] ex_pc, ex_imm, ex_a, ex_b;
  logic [4:0]  ex_rs, ex_rt, ex_rw;
  logic [15:0] ex_ctrl;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  logic [31:0] gpr [32];

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_ctrl(id_ctrl), .gpr_rd1(gpr_rd1), .gpr_rd2(gpr_rd2),
    .ex_fwd_data(ex_fwd_data), .mem_regWrite(mem_regWrite), .mem_rw(mem_rw), .mem_data(mem_data),
    .wb_regWrite(wb_regWrite), .wb_rw(wb_rw), .wb_Wd(wb_Wd), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_a(ex_a), .ex_b(ex_b), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw),
    .ex_ctrl(ex_ctrl)
  );

  // Register file: posedge write, combinational read.
  assign gpr_rd1 = gpr[id_rs];
  assign gpr_rd2 = gpr[id_rt];
  always @(posedge clk) if (wb_regWrite && wb_rw != 5'd0) gpr[wb_rw] <= wb_Wd;

  // Behavioural model of the EX-side state.
  logic        m_valid, m_regWrite, m_memRead;
  logic [31:0] m_pc, m_imm, m_a, m_b;
  logic [4:0]  m_rs, m_rt, m_rw;
  logic [15:0] m_ctrl;

  function automatic logic [31:0] pick(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (m_valid && m_regWrite && !m_memRead && m_rw == r) return ex_fwd_data;
    if (mem_regWrite && mem_rw == r) return mem_data;
    if (wb_regWrite && wb_rw == r) return wb_Wd;
    return gpr[r];
  endfunction

  function automatic logic model_haz();
    return id_valid && m_valid && m_memRead && m_rw != 5'd0 &&
           ((id_use_rs && m_rw == id_rs) || (id_use_rt && m_rw == id_rt));
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] na, nb;
    if (!reset) begin
      m_valid = 0; m_regWrite = 0; m_memRead = 0; m_ctrl = 0;
      m_pc = 0; m_imm = 0; m_a = 0; m_b = 0; m_rs = 0; m_rt = 0; m_rw = 0;
    end else if (flush || (!stall && model_haz())) begin
      m_valid = 0; m_regWrite = 0; m_memRead = 0; m_ctrl = 0;
    end else if (!stall) begin
      na = pick(id_rs);
      nb = pick(id_rt);
      m_valid = id_valid; m_regWrite = id_valid & id_regWrite; m_memRead = id_valid & id_memRead;
      m_ctrl = id_ctrl; m_pc = id_pc; m_imm = id_imm; m_a = na; m_b = nb;
      m_rs = id_rs; m_rt = id_rt; m_rw = id_rw;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare; data fields are don't-care inside a bubble.
  always @(negedge clk) begin
    if (started) begin
      check("cmp_hazard", {31'd0, hazard_stall}, {31'd0, model_haz()});
      check("cmp_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      check("cmp_regWrite", {31'd0, ex_regWrite}, {31'd0, m_regWrite});
      check("cmp_memRead", {31'd0, ex_memRead}, {31'd0, m_memRead});
      check("cmp_ctrl", {16'd0, ex_ctrl}, {16'd0, m_ctrl});
      if (m_valid) begin
        check("cmp_pc", ex_pc, m_pc);
        check("cmp_imm", ex_imm, m_imm);
        check("cmp_a", ex_a, m_a);
        check("cmp_b", ex_b, m_b);
        check("cmp_regs", {17'd0, ex_rs, ex_rt, ex_rw}, {17'd0, m_rs, m_rt, m_rw});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_imm = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; id_rw = 0; id_regWrite = 0; id_memRead = 0; id_ctrl = 0;
    ex_fwd_data = 0; mem_regWrite = 0; mem_rw = 0; mem_data = 0;
    wb_regWrite = 0; wb_rw = 0; wb_Wd = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rw, input logic rwe, input logic ld);
    id_valid = 1; id_pc = pc; id_imm = pc + 32'h4; id_ctrl = pc[15:0] ^ 16'h5A5A;
    id_rs = rs; id_rt = rt; id_use_rs = 1; id_use_rt = 1;
    id_rw = rw; id_regWrite = rwe; id_memRead = ld;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'h1000 + i;
    gpr[0] = 32'hDEAD_BEEF;
    idle();
    // Reset with busy ID inputs
    issue(32'h55, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1);
    #2 started = 1'b1;
    tick(); tick();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_regWrite", {31'd0, ex_regWrite}, 32'd0);
    reset = 1;
    issue(32'h100, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0);
    tick();
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_pc", ex_pc, 32'h100);
    check("post_rst_a", ex_a, 32'h1003);

    // WB bypass beats stale GPR
    idle(); gpr[5] = 32'h11;
    issue(32'h110, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0);
    wb_regWrite = 1; wb_rw = 5'd5; wb_Wd = 32'hAA;
    tick();
    check("wb_bypass_a", ex_a, 32'hAA);

    // EX > MEM > WB priority, r0 reads zero
    idle();
    issue(32'h120, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    tick();
    issue(32'h124, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    ex_fwd_data = 32'h1; mem_regWrite = 1; mem_rw = 5'd7; mem_data = 32'h2;
    wb_regWrite = 1; wb_rw = 5'd7; wb_Wd = 32'h3;
    tick();
    check("prio_ex_b", ex_b, 32'h1);
    check("r0_a", ex_a, 32'h0);
    issue(32'h128, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    tick();
    check("prio_mem_b", ex_b, 32'h2);

    // Load-use hazard then MEM forward
    idle();
    issue(32'h130, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    tick();
    issue(32'h134, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0);
    #1 check("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_hazard_clear", {31'd0, hazard_stall}, 32'd0);
    mem_regWrite = 1; mem_rw = 5'd9; mem_data = 32'h99;
    tick();
    check("lu_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_mem_a", ex_a, 32'h99);

    // Unused source never stalls
    idle();
    issue(32'h140, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    tick();
    issue(32'h144, 5'd3, 5'd9, 5'd11, 1'b1, 1'b0);
    id_use_rt = 0;
    #1 check("nostall_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("nostall_valid", {31'd0, ex_valid}, 32'd1);
    check("nostall_rt", {27'd0, ex_rt}, 32'd9);

    // Hazard under stall holds; flush under hazard bubbles
    idle();
    issue(32'h150, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    tick();
    issue(32'h154, 5'd9, 5'd2, 5'd12, 1'b1, 1'b0);
    stall = 1;
    tick();
    check("haz_stall_hold", {31'd0, ex_memRead}, 32'd1);
    check("haz_stall_pc", ex_pc, 32'h150);
    stall = 0; flush = 1;
    tick();
    check("haz_flush_bubble", {31'd0, ex_valid}, 32'd0);

    // stall+flush same edge, then stall holds 3 cycles
    idle();
    issue(32'h200, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    stall = 1; flush = 1;
    tick();
    check("sf_bubble", {31'd0, ex_valid}, 32'd0);
    idle(); gpr[4] = 32'h44;
    issue(32'h300, 5'd4, 5'd6, 5'd13, 1'b1, 1'b0);
    tick();
    check("load_a", ex_a, 32'h44);
    stall = 1; id_pc = 32'h400; gpr[4] = 32'h55;
    mem_regWrite = 1; mem_rw = 5'd4; mem_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", ex_pc, 32'h300);
      check("stall_a", ex_a, 32'h44);
    end

    // Reset mid-stall clears immediately, stall then holds the bubble
    reset = 0;
    #1 check("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_stall_pc", ex_pc, 32'd0);
    tick();
    reset = 1;
    tick();
    check("rst_stall_hold", {31'd0, ex_valid}, 32'd0);
    stall = 0;
    tick();
    check("resume_pc", ex_pc, 32'h400);
    idle();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
